axi_read_controller: RTL and testbench

Read-path companion to the PCIe-to-AXI-Lite bridge write controller. Accepts single-DWORD memory read requests decoded from PCIe TLPs and translates the BAR-relative address into an AXI4-Lite read. Returns the read data, with completion status, lower address and byte count, to the bridge's completion generator. Sits between the TLP request decoder and the AXI4-Lite master port, in parallel with the write controller.

---
 rtl/axi_read_controller.sv | 181 ++++++++++++++++++
 tb/tb_axi_read_controller.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_controller.sv
// axi_read_controller: turns single-DWORD PCIe memory read requests into
// AXI4-Lite reads and hands the returned data, status, lower address and
// byte count to the completion generator. One read in flight at a time.
module axi_read_controller #(
  parameter int unsigned TCQ               = 1,
  parameter int unsigned M_AXI_TDATA_WIDTH = 32,
  parameter int unsigned M_AXI_ADDR_WIDTH  = 32,
  parameter logic [63:0] BAR0AXI           = 64'h0,
  parameter logic [63:0] BAR1AXI           = 64'h0,
  parameter logic [63:0] BAR2AXI           = 64'h0,
  parameter logic [63:0] BAR3AXI           = 64'h0,
  parameter logic [63:0] BAR4AXI           = 64'h0,
  parameter logic [63:0] BAR5AXI           = 64'h0,
  parameter int unsigned BAR0SIZE          = 12,
  parameter int unsigned BAR1SIZE          = 12,
  parameter int unsigned BAR2SIZE          = 12,
  parameter int unsigned BAR3SIZE          = 12,
  parameter int unsigned BAR4SIZE          = 12,
  parameter int unsigned BAR5SIZE          = 12
) (
  input  logic                         m_axi_aclk,
  input  logic                         m_axi_areset,
  output logic [M_AXI_ADDR_WIDTH-1:0]  m_axi_araddr,
  output logic [2:0]                   m_axi_arprot,
  output logic                         m_axi_arvalid,
  input  logic                         m_axi_arready,
  input  logic [M_AXI_TDATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                   m_axi_rresp,
  input  logic                         m_axi_rvalid,
  output logic                         m_axi_rready,
  input  logic                         mem_req_valid,
  output logic                         mem_req_ready,
  input  logic [2:0]                   mem_req_bar_hit,
  input  logic [31:0]                  mem_req_pcie_address,
  input  logic [3:0]                   mem_req_byte_enable,
  input  logic                         mem_req_write_readn,
  input  logic [15:0]                  mem_req_req_id,
  input  logic [7:0]                   mem_req_tag,
  input  logic [2:0]                   mem_req_tc,
  input  logic [1:0]                   mem_req_attr,
  output logic                         compl_valid,
  input  logic                         compl_ready,
  output logic [31:0]                  compl_data,
  output logic [2:0]                   compl_status,
  output logic [6:0]                   compl_lower_addr,
  output logic [11:0]                  compl_byte_count,
  output logic [15:0]                  compl_req_id,
  output logic [7:0]                   compl_tag,
  output logic [2:0]                   compl_tc,
  output logic [1:0]                   compl_attr
);

  // TCQ is kept so existing parameter maps still bind; registers model no delay.
  localparam int unsigned TCQ_UNUSED = TCQ;

  typedef enum logic [3:0] {
    IDLE      = 4'b0001,
    READ_REQ  = 4'b0010,
    READ_DATA = 4'b0100,
    CPL_REQ   = 4'b1000
  } state_t;

  state_t state, state_next;

  logic accept;
  logic bar_ok;
  logic unused_rresp;

  assign m_axi_arprot = 3'b000;
  assign unused_rresp = m_axi_rresp[0];
  assign bar_ok       = (mem_req_bar_hit < 3'd6);
  assign accept       = (state == IDLE) && mem_req_valid && mem_req_ready && !mem_req_write_readn;

  // Base bits above the aperture, request DWORD offset inside it.
  function automatic logic [M_AXI_ADDR_WIDTH-1:0] map_addr(
    input logic [63:0] base, input int unsigned size, input logic [31:0] addr);
    logic [M_AXI_ADDR_WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < M_AXI_ADDR_WIDTH; i++) begin
      if (i < 2)                     r[i] = 1'b0;
      else if (i < size && i < 32)   r[i] = addr[i];
      else                           r[i] = base[i];
    end
    return r;
  endfunction

  function automatic logic [1:0] be_low(input logic [3:0] be);
    logic [1:0] lo;
    lo = 2'b00;
    if (be[0] || be == 4'b0000) lo = 2'b00;
    else if (be[1])             lo = 2'b01;
    else if (be[2])             lo = 2'b10;
    else                        lo = 2'b11;
    return lo;
  endfunction

  function automatic logic [11:0] be_count(input logic [3:0] be);
    logic [11:0] n;
    casez (be)
      4'b1??1:                   n = 12'd4;
      4'b01?1, 4'b1?10:          n = 12'd3;
      4'b0011, 4'b0110, 4'b1100: n = 12'd2;
      default:                   n = 12'd1;
    endcase
    return n;
  endfunction

  // State register.
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) state <= IDLE;
    else              state <= state_next;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_next    = state;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    compl_valid   = 1'b0;
    case (state)
      IDLE:      if (accept) state_next = bar_ok ? READ_REQ : CPL_REQ;
      READ_REQ: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_next = READ_DATA;
      end
      READ_DATA: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) state_next = CPL_REQ;
      end
      CPL_REQ: begin
        compl_valid = 1'b1;
        if (compl_ready) state_next = IDLE;
      end
      default:   state_next = IDLE;
    endcase
  end

  // Request capture, read-data capture and registered ready.
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      mem_req_ready    <= 1'b0;
      m_axi_araddr     <= '0;
      compl_data       <= '0;
      compl_status     <= '0;
      compl_lower_addr <= '0;
      compl_byte_count <= '0;
      compl_req_id     <= '0;
      compl_tag        <= '0;
      compl_tc         <= '0;
      compl_attr       <= '0;
    end else begin
      mem_req_ready <= (state_next == IDLE);
      if (accept) begin
        case (mem_req_bar_hit)
          3'd0:    m_axi_araddr <= map_addr(BAR0AXI, BAR0SIZE, mem_req_pcie_address);
          3'd1:    m_axi_araddr <= map_addr(BAR1AXI, BAR1SIZE, mem_req_pcie_address);
          3'd2:    m_axi_araddr <= map_addr(BAR2AXI, BAR2SIZE, mem_req_pcie_address);
          3'd3:    m_axi_araddr <= map_addr(BAR3AXI, BAR3SIZE, mem_req_pcie_address);
          3'd4:    m_axi_araddr <= map_addr(BAR4AXI, BAR4SIZE, mem_req_pcie_address);
          3'd5:    m_axi_araddr <= map_addr(BAR5AXI, BAR5SIZE, mem_req_pcie_address);
          default: m_axi_araddr <= '0;
        endcase
        compl_lower_addr <= {mem_req_pcie_address[6:2], be_low(mem_req_byte_enable)};
        compl_byte_count <= be_count(mem_req_byte_enable);
        compl_req_id     <= mem_req_req_id;
        compl_tag        <= mem_req_tag;
        compl_tc         <= mem_req_tc;
        compl_attr       <= mem_req_attr;
        if (!bar_ok) begin
          compl_data   <= '0;
          compl_status <= 3'b001;
        end
      end
      if (state == READ_DATA && m_axi_rvalid) begin
        compl_data   <= m_axi_rdata[31:0];
        compl_status <= m_axi_rresp[1] ? 3'b100 : 3'b000;
      end
    end
  end

endmodule

// File: tb/tb_axi_read_controller.sv
// tb_axi_read_controller: directed reads against a delay-configurable AXI
// slave, with a transaction-level model checked on every cycle.
module tb_axi_read_controller;

  localparam logic [63:0] B0 = 64'h0000_0000_44A0_0000;
  localparam logic [63:0] B1 = 64'h0000_0000_C000_0000;
  localparam logic [63:0] B2 = 64'h0000_0001_2345_8000;
  localparam int unsigned S0 = 12, S1 = 20, S2 = 3;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid, arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0, rready;
  logic        req_valid = 1'b0, req_ready;
  logic [2:0]  req_bar = '0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_be = '0;
  logic        req_wr = 1'b0;
  logic [15:0] req_id = '0;
  logic [7:0]  req_tag = '0;
  logic [2:0]  req_tc = '0;
  logic [1:0]  req_attr = '0;
  logic        c_valid, c_ready = 1'b0;
  logic [31:0] c_data;
  logic [2:0]  c_status;
  logic [6:0]  c_lower;
  logic [11:0] c_bc;
  logic [15:0] c_id;
  logic [7:0]  c_tag;
  logic [2:0]  c_tc;
  logic [1:0]  c_attr;

  always #5 clk = ~clk;

  axi_read_controller #(
    .BAR0AXI(B0), .BAR0SIZE(S0),
    .BAR1AXI(B1), .BAR1SIZE(S1),
    .BAR2AXI(B2), .BAR2SIZE(S2)
  ) dut (
    .m_axi_aclk(clk), .m_axi_areset(rst),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .mem_req_valid(req_valid), .mem_req_ready(req_ready),
    .mem_req_bar_hit(req_bar), .mem_req_pcie_address(req_addr),
    .mem_req_byte_enable(req_be), .mem_req_write_readn(req_wr),
    .mem_req_req_id(req_id), .mem_req_tag(req_tag),
    .mem_req_tc(req_tc), .mem_req_attr(req_attr),
    .compl_valid(c_valid), .compl_ready(c_ready),
    .compl_data(c_data), .compl_status(c_status),
    .compl_lower_addr(c_lower), .compl_byte_count(c_bc),
    .compl_req_id(c_id), .compl_tag(c_tag),
    .compl_tc(c_tc), .compl_attr(c_attr)
  );

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_araddr(input logic [2:0] bar, input logic [31:0] a);
    logic [63:0] base, mask;
    int unsigned sz;
    case (bar)
      3'd0:    begin base = B0; sz = S0; end
      3'd1:    begin base = B1; sz = S1; end
      3'd2:    begin base = B2; sz = S2; end
      default: begin base = 64'h0; sz = 12; end
    endcase
    mask = (64'd1 << sz) - 64'd1;
    return 32'(((base & ~mask) | ({32'h0, a} & mask)) & ~64'd3);
  endfunction

  function automatic int m_first(input logic [3:0] be);
    for (int i = 0; i < 4; i++) if (be[i]) return i;
    return 0;
  endfunction

  function automatic int m_bc(input logic [3:0] be);
    int last;
    if (be == 4'b0000) return 1;
    last = 0;
    for (int i = 0; i < 4; i++) if (be[i]) last = i;
    return last - m_first(be) + 1;
  endfunction

  // ---------------- AXI slave and completion sink ----------------
  int ar_delay = 0, r_delay = 0, cr_delay = 0;
  logic [31:0] s_data = '0;
  logic [1:0]  s_resp = '0;

  initial begin
    int ar_cnt, r_cnt, c_cnt;
    bit in_r, ar_hs, r_hs, c_hs;
    ar_cnt = 0; r_cnt = 0; c_cnt = 0; in_r = 0; ar_hs = 0; r_hs = 0; c_hs = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        arready = 0; rvalid = 0; c_ready = 0;
        ar_cnt = 0; r_cnt = 0; c_cnt = 0; in_r = 0; ar_hs = 0; r_hs = 0; c_hs = 0;
      end else begin
        if (ar_hs) begin arready = 0; ar_cnt = 0; in_r = 1; r_cnt = 0; end
        if (r_hs)  begin rvalid = 0; in_r = 0; end
        if (c_hs)  begin c_ready = 0; c_cnt = 0; end
        if (!in_r && arvalid) begin
          if (ar_cnt >= ar_delay) arready = 1; else ar_cnt++;
        end
        if (in_r && !rvalid) begin
          if (r_cnt >= r_delay) begin rvalid = 1; rdata = s_data; rresp = s_resp; end
          else r_cnt++;
        end
        if (c_valid && !c_ready) begin
          if (c_cnt >= cr_delay) c_ready = 1; else c_cnt++;
        end
        ar_hs = arvalid && arready;
        r_hs  = rvalid && rready;
        c_hs  = c_valid && c_ready;
      end
    end
  end

  // ---------------- monitor / compare ----------------
  int cyc = 0, ar_count = 0, cpl_count = 0, accept_cyc = 0, cv_rise_cyc = 0;
  bit was_reset = 1, exp_ready = 0, outstanding = 0, e_bar_ok = 0, ar_done = 0, r_done = 0;
  logic [31:0] e_araddr, cap_data, last_araddr, last_data;
  logic [1:0]  cap_resp;
  logic [6:0]  e_lower, last_lower;
  logic [11:0] e_bc, last_bc;
  logic [15:0] e_id;
  logic [7:0]  e_tag, last_tag;
  logic [2:0]  e_tc, last_status;
  logic [1:0]  e_attr;

  initial begin
    bit prev_ar_wait, prev_c_wait, prev_cv;
    logic [31:0] prev_araddr;
    logic [72:0] prev_snap, snap;
    logic [31:0] ed;
    logic [2:0]  es;
    prev_ar_wait = 0; prev_c_wait = 0; prev_cv = 0; prev_araddr = '0; prev_snap = '0;
    forever begin
      @(negedge clk); #1; cyc++;
      snap = {c_data, c_status, c_lower, c_bc, c_id, c_tag, c_tc, c_attr};
      chk("arprot", arprot, 3'b000);
      if (was_reset) begin
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_cvalid", c_valid, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_cdata", c_data, 0);
        chk("rst_cstatus", c_status, 0);
      end else begin
        chk("req_ready", req_ready, exp_ready);
        if (!(outstanding && e_bar_ok && !ar_done)) chk("arvalid_idle", arvalid, 0);
        if (!(outstanding && e_bar_ok && ar_done && !r_done)) chk("rready_idle", rready, 0);
        if (!(outstanding && (!e_bar_ok || r_done))) chk("cvalid_idle", c_valid, 0);
        if (prev_ar_wait) begin
          chk("ar_hold", arvalid, 1);
          chk("araddr_hold", araddr, prev_araddr);
        end
        if (prev_c_wait) begin
          chk("cvalid_hold", c_valid, 1);
          chk("compl_hold", snap, prev_snap);
        end
        if (c_valid && !prev_cv) cv_rise_cyc = cyc;
      end
      if (rst) begin
        was_reset = 1; exp_ready = 0; outstanding = 0; ar_done = 0; r_done = 0;
        prev_ar_wait = 0; prev_c_wait = 0; prev_cv = 0;
      end else begin
        was_reset = 0;
        if (arvalid && arready) begin
          ar_count++; ar_done = 1; last_araddr = araddr;
          chk("araddr", araddr, e_araddr);
        end
        if (rvalid && rready) begin r_done = 1; cap_data = rdata; cap_resp = rresp; end
        if (c_valid && c_ready) begin
          cpl_count++;
          ed = e_bar_ok ? cap_data : 32'h0;
          es = !e_bar_ok ? 3'b001 : (cap_resp[1] ? 3'b100 : 3'b000);
          chk("compl_data", c_data, ed);
          chk("compl_status", c_status, es);
          chk("compl_lower", c_lower, e_lower);
          chk("compl_bc", c_bc, e_bc);
          chk("compl_echo", {c_id, c_tag, c_tc, c_attr}, {e_id, e_tag, e_tc, e_attr});
          last_data = c_data; last_status = c_status; last_lower = c_lower;
          last_bc = c_bc; last_tag = c_tag;
          outstanding = 0;
        end else if (!outstanding && req_valid && req_ready && !req_wr) begin
          outstanding = 1; ar_done = 0; r_done = 0; accept_cyc = cyc;
          e_bar_ok = (req_bar < 3'd6);
          e_araddr = m_araddr(req_bar, req_addr);
          e_lower  = {req_addr[6:2], 2'(m_first(req_be))};
          e_bc     = 12'(m_bc(req_be));
          e_id = req_id; e_tag = req_tag; e_tc = req_tc; e_attr = req_attr;
        end
        exp_ready    = !outstanding;
        prev_ar_wait = arvalid && !arready;
        prev_araddr  = araddr;
        prev_c_wait  = c_valid && !c_ready;
        prev_snap    = snap;
        prev_cv      = c_valid;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_read(input logic [2:0] bar, input logic [31:0] addr,
                            input logic [3:0] be, input logic [7:0] tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) chk("ready_timeout", 0, 1);
    req_valid = 1; req_wr = 0; req_bar = bar; req_addr = addr; req_be = be;
    req_tag = tag; req_id = {8'h5A, tag}; req_tc = tag[2:0]; req_attr = tag[4:3];
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic do_read(input logic [2:0] bar, input logic [31:0] addr, input logic [3:0] be,
                         input logic [7:0] tag, input logic [31:0] data, input logic [1:0] resp,
                         input int ard, input int rd, input int crd);
    int c0, n;
    ar_delay = ard; r_delay = rd; cr_delay = crd; s_data = data; s_resp = resp;
    c0 = cpl_count;
    start_read(bar, addr, be, tag);
    n = 0;
    while (cpl_count == c0 && n < 200) begin @(negedge clk); n++; end
    if (cpl_count == c0) chk("cpl_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int a0, c0, n;
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);

    // BAR0 full-DWORD read, zero wait states
    do_read(3'd0, 32'h0000_0A34, 4'b1111, 8'h01, 32'h1234_5678, 2'b00, 0, 0, 0);
    chk("t1_araddr", last_araddr, 32'h44A0_0A34);
    chk("t1_data", last_data, 32'h1234_5678);
    chk("t1_status", last_status, 3'b000);
    chk("t1_lower", last_lower, 7'h34);
    chk("t1_bc", last_bc, 12'd4);
    chk("t1_latency", cv_rise_cyc - accept_cyc, 3);

    // Byte-enable decode
    do_read(3'd0, 32'h0000_0008, 4'b0100, 8'h02, 32'hCAFE_F00D, 2'b00, 0, 0, 0);
    chk("t2_lower", last_lower, 7'h0A);
    chk("t2_bc", last_bc, 12'd1);
    do_read(3'd0, 32'h0000_0008, 4'b0110, 8'h03, 32'h0BAD_BEEF, 2'b01, 0, 0, 0);
    chk("t3_lower", last_lower, 7'h09);
    chk("t3_bc", last_bc, 12'd2);
    chk("t3_status", last_status, 3'b000);

    // BAR1, wide aperture, BE=1010
    do_read(3'd1, 32'h1234_5678, 4'b1010, 8'h04, 32'h89AB_CDEF, 2'b00, 1, 2, 1);
    chk("t4_araddr", last_araddr, 32'hC004_5678);
    chk("t4_lower", last_lower, 7'h79);
    chk("t4_bc", last_bc, 12'd3);

    // Slave error response
    do_read(3'd0, 32'h0000_0100, 4'b1111, 8'h05, 32'hDEAD_0000, 2'b10, 0, 0, 0);
    chk("t5_status", last_status, 3'b100);

    // Invalid BAR: no AR, unsupported-request completion
    a0 = ar_count;
    do_read(3'd7, 32'h0000_0040, 4'b1111, 8'h06, 32'hFFFF_FFFF, 2'b00, 0, 0, 0);
    chk("t6_no_ar", ar_count - a0, 0);
    chk("t6_status", last_status, 3'b001);
    chk("t6_data", last_data, 32'h0);
    chk("t6_latency", cv_rise_cyc - accept_cyc, 1);

    // Backpressure on every channel
    a0 = ar_count; c0 = cpl_count;
    do_read(3'd0, 32'h0000_0F00, 4'b0011, 8'hA5, 32'h5555_AAAA, 2'b00, 5, 7, 4);
    chk("t7_one_ar", ar_count - a0, 1);
    chk("t7_one_cpl", cpl_count - c0, 1);
    chk("t7_tag", last_tag, 8'hA5);
    chk("t7_data", last_data, 32'h5555_AAAA);

    // Write request is ignored
    a0 = ar_count; c0 = cpl_count;
    @(negedge clk);
    req_valid = 1; req_wr = 1; req_bar = 3'd0; req_addr = 32'h10; req_be = 4'hF;
    repeat (3) @(negedge clk);
    req_valid = 0; req_wr = 0;
    repeat (3) @(negedge clk);
    chk("t8_no_ar", ar_count - a0, 0);
    chk("t8_no_cpl", cpl_count - c0, 0);
    chk("t8_ready", req_ready, 1);

    // Reset while waiting for read data
    ar_delay = 0; r_delay = 40; cr_delay = 0; s_data = 32'h7777_7777; s_resp = 2'b00;
    start_read(3'd0, 32'h0000_0200, 4'b1111, 8'h07);
    n = 0;
    while (!rready && n < 20) begin @(negedge clk); n++; end
    chk("t9_in_rdata", rready, 1);
    rst = 1;
    @(posedge clk); #1;
    chk("t9_arvalid", arvalid, 0);
    chk("t9_rready", rready, 0);
    chk("t9_cvalid", c_valid, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    do_read(3'd2, 32'h0000_0F04, 4'b1000, 8'h08, 32'h0102_0304, 2'b00, 0, 0, 0);
    chk("t10_araddr", last_araddr, 32'h2345_8004);
    chk("t10_lower", last_lower, 7'h07);
    chk("t10_bc", last_bc, 12'd1);
    chk("t10_data", last_data, 32'h0102_0304);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
